// File: rtl/axis2fifo_pkt.sv
// AXI-Stream ingress circular buffer with programmable ready threshold and FWFT word-level read port.
// Optional complete-packet tracking enabled by defining AXIS2FIFO_PKT_EN.
module axis2fifo_pkt #(
  parameter  int unsigned DW       = 8,
  parameter  int unsigned UDW      = 10,
  parameter  int unsigned DEW      = DW / 8,
  parameter  int unsigned DEPTH    = 16,
  parameter  int unsigned AF_LEVEL = DEPTH - 2,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned FW       = DW + DEW + UDW + 1
) (
  input  logic           clk_sys,
  input  logic           rst_n,
  output logic           axi_ready,
  input  logic           axi_valid,
  input  logic [DW-1:0]  axi_data,
  input  logic           axi_last,
  input  logic [DEW-1:0] axi_keep,
  input  logic [UDW-1:0] axi_user,
  input  logic           fifo_rd_en,
  output logic [FW-1:0]  fifo_rd_data,
  output logic           fifo_empty,
  output logic           fifo_eflag,
  output logic [AW:0]    fifo_count,
  output logic           pkt_avail
);

  localparam logic [AW:0] AF_CNT  = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  logic [FW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic          r_ready;
  logic          r_arm;

  logic          w_wr;
  logic          w_rd;
  logic [AW:0]   w_count_nxt;
  logic [FW-1:0] w_head;

  assign w_wr   = axi_valid & r_ready;
  assign w_rd   = fifo_rd_en & ~r_empty;
  assign w_head = r_mem[r_rd_ptr];

  assign axi_ready    = r_ready;
  assign fifo_count   = r_count;
  assign fifo_empty   = r_empty;
  assign fifo_rd_data = r_empty ? '0 : w_head;
  assign fifo_eflag   = (r_count == CNT_ONE) & fifo_rd_en;

  // Storage array is intentionally left out of reset.
  always_ff @(posedge clk_sys) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {axi_user, axi_keep, axi_last, axi_data};
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // r_arm delays ready by one extra edge after reset release.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_ready  <= 1'b0;
      r_arm    <= 1'b0;
    end else begin
      r_arm   <= 1'b1;
      r_ready <= r_arm & (r_count <= AF_CNT);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

`ifdef AXIS2FIFO_PKT_EN
  logic [AW:0] r_pkt_cnt;
  logic        r_pkt_avail;
  logic [AW:0] w_pkt_nxt;
  logic        w_pkt_in;
  logic        w_pkt_out;

  assign w_pkt_in  = w_wr & axi_last;
  assign w_pkt_out = w_rd & w_head[DW];
  assign pkt_avail = r_pkt_avail;

  always_comb begin
    w_pkt_nxt = r_pkt_cnt;
    case ({w_pkt_in, w_pkt_out})
      2'b10:   w_pkt_nxt = r_pkt_cnt + CNT_ONE;
      2'b01:   w_pkt_nxt = r_pkt_cnt - CNT_ONE;
      default: w_pkt_nxt = r_pkt_cnt;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt   <= '0;
      r_pkt_avail <= 1'b0;
    end else begin
      r_pkt_cnt   <= w_pkt_nxt;
      r_pkt_avail <= (w_pkt_nxt != '0);
    end
  end
`else
  assign pkt_avail = ~r_empty;
`endif

endmodule
